// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and frame constants for the boot-time program loader
package loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
    localparam logic [7:0] MAGIC = 8'hA5;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream into little-endian RAM words and holds the CPU in reset until the checksum verifies
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_cpu_rst,
    output logic                  o_done,
    output logic                  o_err
);
    localparam logic [32:0] LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

    state_t      state, nxt;
    logic [1:0]  bcnt;
    logic [31:0] len, cnt;
    logic [23:0] word;
    logic [7:0]  csum;
    logic        acc, last_byte, magic_hit;
    logic [31:0] len_nxt, word_nxt;

    assign acc       = i_byte_valid && o_byte_ready;
    assign last_byte = bcnt == 2'd3;
    assign magic_hit = acc && (state == IDLE || state == ERR) && i_byte == MAGIC;
    assign len_nxt   = {i_byte, len[31:8]};
    assign word_nxt  = {i_byte, word};

    assign o_byte_ready = !o_mem_we;
    assign o_done       = state == DONE;
    assign o_err        = state == ERR;
    assign o_cpu_rst    = state != DONE;

    always_comb begin
        nxt = state;
        if (acc) begin
            case (state)
                IDLE, ERR: if (i_byte == MAGIC) nxt = LEN;
                LEN:       if (last_byte) nxt = ({1'b0, len_nxt} > LIMIT) ? ERR : (len_nxt == 32'd0) ? CSUM : DATA;
                DATA:      if (last_byte && cnt + 32'd1 == len) nxt = CSUM;
                CSUM:      nxt = (i_byte == csum) ? DONE : ERR;
                default:   nxt = state;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= nxt;
    end

    // bcnt wraps 3->0 at the end of LEN, so DATA starts word-aligned
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bcnt        <= 2'd0;
            len         <= 32'd0;
            cnt         <= 32'd0;
            word        <= 24'd0;
            csum        <= 8'd0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= 32'd0;
        end else begin
            o_mem_we <= 1'b0;
            if (magic_hit) begin
                bcnt <= 2'd0;
                cnt  <= 32'd0;
                csum <= 8'd0;
            end
            if (acc && state == LEN) begin
                len  <= len_nxt;
                bcnt <= bcnt + 2'd1;
            end
            if (acc && state == DATA) begin
                word <= word_nxt[31:8];
                csum <= csum ^ i_byte;
                bcnt <= bcnt + 2'd1;
                if (last_byte) begin
                    o_mem_we    <= 1'b1;
                    o_mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + cnt[ADDR_WIDTH-1:0];
                    o_mem_wdata <= word_nxt;
                    cnt         <= cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader against a frame-level reference model
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];

    logic clk = 0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  byte_a, byte_b;
    logic        valid_a, valid_b;
    logic        ready_a, we_a, cpu_rst_a, done_a, err_a;
    logic        ready_b, we_b, cpu_rst_b, done_b, err_b;
    logic [11:0] addr_a;
    logic [3:0]  addr_b;
    logic [31:0] wdata_a, wdata_b;

    int checks = 0;
    int errors = 0;
    int low_a  = 0;
    logic [63:0] obs_a[$], obs_b[$], exp_q[$];

    prog_loader dut_a (
        .i_clk(clk), .i_rst(rst), .i_byte(byte_a), .i_byte_valid(valid_a), .o_byte_ready(ready_a),
        .o_mem_we(we_a), .o_mem_addr(addr_a), .o_mem_wdata(wdata_a),
        .o_cpu_rst(cpu_rst_a), .o_done(done_a), .o_err(err_a)
    );

    prog_loader #(.ADDR_WIDTH(4), .BASE_ADDR(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_byte(byte_b), .i_byte_valid(valid_b), .o_byte_ready(ready_b),
        .o_mem_we(we_b), .o_mem_addr(addr_b), .o_mem_wdata(wdata_b),
        .o_cpu_rst(cpu_rst_b), .o_done(done_b), .o_err(err_b)
    );

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ready_a !== !we_a) begin
                errors++;
                $display("FAIL ready_a: ready=%b while we=%b", ready_a, we_a);
            end
            if (we_a) obs_a.push_back({32'(addr_a), wdata_a});
            if (!ready_a) low_a++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ready_b !== !we_b) begin
                errors++;
                $display("FAIL ready_b: ready=%b while we=%b", ready_b, we_b);
            end
            if (we_b) obs_b.push_back({32'(addr_b), wdata_b});
        end
    end

    // Reference: walks the stream frame by frame; expected writes go to exp_q as {addr, data}
    task automatic model(input bq_t s, input int aw, input int base, output logic edone, output logic eerr);
        int i = 0;
        longint limit = (longint'(1) << aw) - longint'(base);
        longint n, k;
        logic [7:0] cs;
        exp_q.delete();
        edone = 0;
        eerr = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            eerr = 0;
            if (i + 4 > s.size()) break;
            n = longint'({s[i+3], s[i+2], s[i+1], s[i]});
            i += 4;
            if (n > limit) begin
                eerr = 1;
                continue;
            end
            cs = 0;
            k = 0;
            while (k < n && i + 4 <= s.size()) begin
                cs = cs ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                exp_q.push_back({32'(longint'(base) + k), s[i+3], s[i+2], s[i+1], s[i]});
                i += 4;
                k++;
            end
            if (k < n || i >= s.size()) break;
            if (s[i] == cs) begin
                edone = 1;
                break;
            end
            eerr = 1;
            i++;
        end
    endtask

    function automatic bq_t build_frame(input int n, input bit good);
        bq_t q;
        logic [7:0] cs = 0, d;
        q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) q.push_back(8'(n >> (8 * i)));
        for (int i = 0; i < 4 * n; i++) begin
            d = 8'($urandom);
            cs ^= d;
            q.push_back(d);
        end
        q.push_back(good ? cs : cs ^ 8'($urandom_range(1, 255)));
        return q;
    endfunction

    task automatic send_byte(input bit which, input logic [7:0] b, input int gap);
        int stall = 0;
        logic r;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (which) valid_b = 0; else valid_a = 0;
        end
        @(negedge clk);
        if (which) begin byte_b = b; valid_b = 1; end
        else begin byte_a = b; valid_a = 1; end
        forever begin
            r = which ? ready_b : ready_a;
            @(posedge clk);
            if (r || stall == 4) break;
            stall++;
            @(negedge clk);
        end
        checks++;
        if (!r) begin
            errors++;
            $display("FAIL accept: byte %h still not accepted after %0d stalled cycles", b, stall);
        end
    endtask

    task automatic stop(input bit which);
        @(negedge clk);
        if (which) valid_b = 0; else valid_a = 0;
    endtask

    task automatic send_seq(input bit which, input bq_t s, input int maxgap);
        foreach (s[i]) send_byte(which, s[i], $urandom_range(0, maxgap));
        stop(which);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        valid_a = 0;
        valid_b = 0;
        @(negedge clk);
        obs_a.delete();
        obs_b.delete();
        low_a = 0;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        valid_a = 0;
        valid_b = 0;
        byte_a = 0;
        byte_b = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready_a, we_a, addr_a, wdata_a, cpu_rst_a, done_a, err_a} !== {1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b, need 1 0 000 00000000 1 0 0",
                     ready_a, we_a, addr_a, wdata_a, cpu_rst_a, done_a, err_a);
        end
        checks++;
        if ({ready_b, we_b, addr_b, wdata_b, cpu_rst_b, done_b, err_b} !== {1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b, need 1 0 0 00000000 1 0 0",
                     ready_b, we_b, addr_b, wdata_b, cpu_rst_b, done_b, err_b);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        bq_t f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_reset();
        send_seq(0, f, 2);
        checks++;
        if (cpu_rst_a !== 1 || done_a !== 0) begin
            errors++;
            $display("FAIL basic_pre: cpu_rst=%b done=%b before checksum, need 1 0", cpu_rst_a, done_a);
        end
        send_byte(0, 8'hB0, 0);
        stop(0);
        checks++;
        if (done_a !== 1 || cpu_rst_a !== 0 || err_a !== 0) begin
            errors++;
            $display("FAIL basic_done: done=%b cpu_rst=%b err=%b, need 1 0 0", done_a, cpu_rst_a, err_a);
        end
        checks++;
        if (obs_a.size() != 2 || obs_a[0] !== {32'd0, 32'h00100513} || obs_a[1] !== {32'd1, 32'h00200593}) begin
            errors++;
            $display("FAIL basic_writes: %0d writes, first=%h, need 2 writes 00000000_00100513, 00000001_00200593",
                     obs_a.size(), obs_a.size() > 0 ? obs_a[0] : 64'h0);
        end
    endtask

    task automatic test_bad_then_good();
        bq_t f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
        bq_t g;
        do_reset();
        send_seq(0, f, 1);
        checks++;
        if (err_a !== 1 || cpu_rst_a !== 1 || done_a !== 0 || obs_a.size() != 2) begin
            errors++;
            $display("FAIL bad_csum: err=%b cpu_rst=%b done=%b writes=%0d, need 1 1 0 2", err_a, cpu_rst_a, done_a, obs_a.size());
        end
        send_byte(0, 8'hA5, 0);
        stop(0);
        checks++;
        if (err_a !== 0) begin
            errors++;
            $display("FAIL err_clear: err=%b after new A5, need 0", err_a);
        end
        g = f[1:12];
        g.push_back(8'hB0);
        send_seq(0, g, 1);
        checks++;
        if (done_a !== 1 || cpu_rst_a !== 0 || obs_a.size() != 4 || obs_a[3] !== {32'd1, 32'h00200593}) begin
            errors++;
            $display("FAIL good_after_bad: done=%b cpu_rst=%b writes=%0d, need 1 0 4", done_a, cpu_rst_a, obs_a.size());
        end
    endtask

    task automatic test_garbage();
        bq_t s = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        send_seq(0, s, 2);
        checks++;
        if (done_a !== 1 || err_a !== 0 || obs_a.size() != 0) begin
            errors++;
            $display("FAIL garbage_empty: done=%b err=%b writes=%0d, need 1 0 0", done_a, err_a, obs_a.size());
        end
    endtask

    task automatic test_len_limit();
        bq_t s = '{8'hA5, 8'h09, 8'h00, 8'h00, 8'h00};
        logic ed, ee;
        do_reset();
        send_seq(1, s, 1);
        checks++;
        if (err_b !== 1 || obs_b.size() != 0) begin
            errors++;
            $display("FAIL len_over: err=%b writes=%0d after N=9, need 1 0", err_b, obs_b.size());
        end
        do_reset();
        s = build_frame(8, 1);
        model(s, 4, 8, ed, ee);
        send_seq(1, s, 2);
        checks++;
        if (done_b !== 1 || err_b !== 0 || obs_b.size() != 8) begin
            errors++;
            $display("FAIL len_max: done=%b err=%b writes=%0d, need 1 0 8", done_b, err_b, obs_b.size());
        end
        for (int k = 0; k < 8 && k < obs_b.size(); k++) begin
            checks++;
            if (obs_b[k] !== exp_q[k] || obs_b[k][63:32] !== 32'(8 + k)) begin
                errors++;
                $display("FAIL len_max_w%0d: got %h, need %h", k, obs_b[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = $urandom_range(3, 6);
        bq_t s = build_frame(n, 1);
        logic ed, ee;
        do_reset();
        model(s, 12, 0, ed, ee);
        send_seq(0, s, 0);
        checks++;
        if (low_a != n) begin
            errors++;
            $display("FAIL b2b_stalls: ready low %0d cycles, need %0d", low_a, n);
        end
        checks++;
        if (obs_a.size() != exp_q.size() || done_a !== ed) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d done=%b, need %0d %b", obs_a.size(), done_a, exp_q.size(), ed);
        end
        foreach (exp_q[k]) begin
            checks++;
            if (k < obs_a.size() && obs_a[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL b2b_w%0d: got %h, need %h", k, obs_a[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bq_t f1 = build_frame(4, 1);
        bq_t f2 = build_frame(3, 1);
        logic [63:0] want[$];
        logic ed, ee;
        do_reset();
        model(f1[0:10], 12, 0, ed, ee);
        want = exp_q;
        send_seq(0, f1[0:10], 0);
        #2 rst = 1;
        #1;
        checks++;
        if ({ready_a, we_a, addr_a, wdata_a, cpu_rst_a, done_a, err_a} !== {1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_rst: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b, need 1 0 000 00000000 1",
                     ready_a, we_a, addr_a, wdata_a, cpu_rst_a);
        end
        @(negedge clk);
        rst = 0;
        model(f2, 12, 0, ed, ee);
        want = {want, exp_q};
        send_seq(0, f2, 1);
        checks++;
        if (obs_a.size() != want.size() || done_a !== 1) begin
            errors++;
            $display("FAIL rst_mid_count: writes=%0d done=%b, need %0d 1", obs_a.size(), done_a, want.size());
        end
        foreach (want[k]) begin
            checks++;
            if (k < obs_a.size() && obs_a[k] !== want[k]) begin
                errors++;
                $display("FAIL rst_mid_w%0d: got %h, need %h", k, obs_a[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        bq_t s;
        logic [63:0] got[$];
        logic ed, ee;
        bit which;
        for (int it = 0; it < 8; it++) begin
            which = it[0];
            s.delete();
            repeat ($urandom_range(0, 3)) s.push_back(8'($urandom));
            s = {s, build_frame($urandom_range(0, which ? 9 : 6), $urandom_range(0, 1) == 1)};
            repeat ($urandom_range(0, 3)) s.push_back(8'($urandom));
            s = {s, build_frame($urandom_range(0, which ? 9 : 6), $urandom_range(0, 2) != 0)};
            do_reset();
            model(s, which ? 4 : 12, which ? 8 : 0, ed, ee);
            send_seq(which, s, 3);
            got = which ? obs_b : obs_a;
            checks++;
            if (got.size() != exp_q.size() || (which ? done_b : done_a) !== ed || (which ? err_b : err_a) !== ee
                || (which ? cpu_rst_b : cpu_rst_a) !== !ed) begin
                errors++;
                $display("FAIL rand%0d: writes=%0d done=%b err=%b, need %0d %b %b", it, got.size(),
                         which ? done_b : done_a, which ? err_b : err_a, exp_q.size(), ed, ee);
            end
            foreach (exp_q[k]) begin
                checks++;
                if (k < got.size() && got[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand%0d_w%0d: got %h, need %h", it, k, got[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_then_good();
        test_garbage();
        test_len_limit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
